// File: rtl/qout_run_meter.sv
// qout_run_meter: measures the length of each constant-level run on qin and
// emits one {level, length, saturated} record per completed run over a
// valid/ready handshake. Records that arrive while an undelivered record is
// stalled are dropped and remembered in a sticky drop_flag.
//
// Optional build macro QRUN_DROP_CNT_EN adds an 8-bit saturating drop_cnt
// output counting dropped records.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | just out of reset; next edge latches the first level
// RUN   | counting the current run; a level change completes a record
module qout_run_meter #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qin,
  input  logic             clr_drop,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_level,
  output logic [LEN_W-1:0] out_len,
  output logic             out_sat,
`ifdef QRUN_DROP_CNT_EN
  output logic [7:0]       drop_cnt,
`endif
  output logic             drop_flag
);

  localparam logic [LEN_W-1:0] MAX = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic             cur_level, cur_level_nxt;
  logic [LEN_W-1:0] run_cnt, run_cnt_nxt;
  logic             sat, sat_nxt;
  logic             complete;

  logic             xfer, load, drop;
  logic             out_valid_nxt, out_level_nxt, out_sat_nxt;
  logic [LEN_W-1:0] out_len_nxt;
  logic             drop_flag_nxt;

  // State, run tracker and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_level <= 1'b0;
      run_cnt   <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_level <= 1'b0;
      out_len   <= '0;
      out_sat   <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_level <= cur_level_nxt;
      run_cnt   <= run_cnt_nxt;
      sat       <= sat_nxt;
      out_valid <= out_valid_nxt;
      out_level <= out_level_nxt;
      out_len   <= out_len_nxt;
      out_sat   <= out_sat_nxt;
      drop_flag <= drop_flag_nxt;
    end
  end

  // Next-state and run counting; the first cycle of every run counts as 1
  always_comb begin
    state_nxt     = state;
    cur_level_nxt = cur_level;
    run_cnt_nxt   = run_cnt;
    sat_nxt       = sat;
    complete      = 1'b0;
    case (state)
      IDLE: begin
        cur_level_nxt = qin;
        run_cnt_nxt   = ONE;
        sat_nxt       = 1'b0;
        state_nxt     = RUN;
      end
      RUN: begin
        if (qin == cur_level) begin
          if (run_cnt == MAX) begin
            sat_nxt = 1'b1;
          end else begin
            run_cnt_nxt = run_cnt + ONE;
          end
        end else begin
          complete      = 1'b1;
          cur_level_nxt = qin;
          run_cnt_nxt   = ONE;
          sat_nxt       = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output register load/hold/drop decisions; a completion coincident with a
  // transfer reloads the slot so back-to-back records have no bubble
  always_comb begin
    xfer          = out_valid & out_ready;
    load          = complete & (~out_valid | out_ready);
    drop          = complete & out_valid & ~out_ready;
    out_valid_nxt = out_valid;
    out_level_nxt = out_level;
    out_len_nxt   = out_len;
    out_sat_nxt   = out_sat;
    if (load) begin
      out_valid_nxt = 1'b1;
      out_level_nxt = cur_level;
      out_len_nxt   = run_cnt;
      out_sat_nxt   = sat;
    end else if (xfer) begin
      out_valid_nxt = 1'b0;
    end
    if (drop) begin
      drop_flag_nxt = 1'b1;
    end else if (clr_drop) begin
      drop_flag_nxt = 1'b0;
    end else begin
      drop_flag_nxt = drop_flag;
    end
  end

`ifdef QRUN_DROP_CNT_EN
  // Saturating count of dropped records; a drop on the clearing edge leaves 1
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= 8'd0;
    end else if (drop) begin
      if (clr_drop) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (clr_drop) begin
      drop_cnt <= 8'd0;
    end
  end
`endif

endmodule
